regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the superscalar datapath: N write ports, M read ports.
//  Adds to the existing register file:
//   - synchronous reset with a sequenced clear
//   - per-port read enables and read-valid outputs
//   - deterministic same-address write priority and conflict flagging
//   - optional write-to-read bypass
//  Sits between the writeback stage (writes) and decode/issue (operand reads).
// PARAMETERS
//  SIZE        32  data width per register
//  REG_NUM     64  number of registers; power of two, >=2
//  READ_PORTS   4  number of read ports, >=1
//  WRITE_PORTS  3  number of write ports, >=1
//  ZERO_REG     1  1: register 0 always reads 0 and writes to it are dropped; 0: register 0 is ordinary
// PORTS
//  clk          in   1                       clock; all state updates on posedge
//  rst          in   1                       synchronous, active-high reset
//  ready        out  1                       1 = clear sequence done, accepting reads/writes
//  wr_en        in   [WRITE_PORTS]           per-port write enable
//  wr_addr      in   [WRITE_PORTS][AW]       write address, AW = $clog2(REG_NUM)
//  wr_data      in   [WRITE_PORTS][SIZE]     write data
//  rd_en        in   [READ_PORTS]            per-port read enable
//  rd_addr      in   [READ_PORTS][AW]        read address
//  rd_data      out  [READ_PORTS][SIZE]      registered read data
//  rd_valid     out  [READ_PORTS]            1 = rd_data of that port updated this cycle
//  wr_conflict  out  1                       registered pulse: >=2 enabled write ports hit the same effective address
// BEHAVIOUR
//  FSM (2 states, CLEAR and RUN):
//   - rst=1 -> CLEAR with clr_cnt=0, from any state; this includes rst mid-clear or mid-run.
//   - CLEAR: each cycle writes 0 to regs[clr_cnt], then clr_cnt++.
//   - After clearing entry REG_NUM-1 -> RUN. CLEAR therefore lasts exactly REG_NUM cycles after rst deasserts.
//  Reset values: ready=0, rd_data=0 (all ports), rd_valid=0, wr_conflict=0, clr_cnt=0.
//  ready: 0 in CLEAR; 1 from the first RUN cycle onward.
//  In CLEAR:
//   - wr_en and rd_en are ignored; no register changes except the clear write.
//   - rd_valid stays 0.
//   - rd_data holds its value.
//  Writes (RUN): on posedge, every enabled port writes regs[wr_addr] <= wr_data.
//   - Same address on several ports: the highest-index port wins; lower ports are dropped.
//   - ZERO_REG=1: writes to address 0 are dropped and are excluded from conflict detection.
//  wr_conflict (RUN): asserted the cycle after a cycle with >=2 enabled ports on the same effective address; 0 otherwise.
//  Reads (RUN): latency 1.
//   - rd_en[i]=1 at edge N -> at N+1: rd_valid[i]=1 and rd_data[i]=regs[rd_addr[i]].
//   - rd_en[i]=0 -> rd_valid[i]=0 and rd_data[i] holds.
//   - ZERO_REG=1 and rd_addr=0 -> rd_data=0 regardless of bypass.
//   - Multiple read ports may read the same address in the same cycle; all return the same value.
//  No output depends combinationally on any input.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//   - a read sampled in the same cycle as a write to the same address returns the NEW data.
//   - With several writers to that address, the winning (highest-index) write is returned.
//  REGFILE_BYPASS_EN undefined:
//   - such a read returns the OLD (pre-write) value.
//   - The write still commits; a read on the following cycle returns the new value.
// STRUCTURE
//  Package regfile_pkg:
//   - state enum rf_state_e {RF_CLEAR, RF_RUN}
//   - localparam-style helper function addr_w(n) = $clog2(n)
//  Sub-module regfile_wr_arb (combinational) computes, from wr_en/wr_addr:
//   - the per-port effective write mask after priority and zero-reg filtering
//   - the conflict flag
//  regfile_mp instantiates regfile_wr_arb once; storage, FSM and read ports live in regfile_mp.
// TESTING
//  1. rst=1 for 3 cycles then 0, REG_NUM=64: ready=0 for 64 cycles, then 1. Every register then reads 0.
//  2. RUN: wr port0 addr5=0xA5A5_0001; next cycle read addr5 on all ports -> every rd_data=0xA5A5_0001 with rd_valid=1.
//  3. Same cycle, ports 0/1/2 write addr9 = 0x11/0x22/0x33.
//     Next cycle: wr_conflict=1 for exactly one cycle. A later read of addr9 returns 0x33.
//  4. Same cycle, write addr7=0xBEEF and read addr7 (addr7 previously 0x1234):
//     with REGFILE_BYPASS_EN -> 0xBEEF; without -> 0x1234, then 0xBEEF on re-read.
//  5. ZERO_REG=1: write addr0=0xFFFF_FFFF on ports 0 and 1 in the same cycle.
//     Next cycle: wr_conflict=0. A read of addr0 returns 0.
//  6. rst=1 for 1 cycle midway through CLEAR, after some RUN writes:
//     ready drops and CLEAR restarts; ready returns after 64 cycles. Previously written registers read 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared types and helpers for the multi-port register file.
//   rf_state_e : controller states (RF_CLEAR sweeps storage to zero, RF_RUN
//                serves reads and writes)
//   addr_w(n)  : address width needed to index n registers
// ---------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_if.sv
// ---------------------------------------------------------------------------
// regfile_if
// Bus between the writeback/decode side (master) and the register file
// (slave).
//   ready       : slave -> master, clear sweep finished
//   wr_en       : per write port enable
//   wr_addr     : per write port address
//   wr_data     : per write port data
//   rd_en       : per read port enable
//   rd_addr     : per read port address
//   rd_data     : per read port registered data
//   rd_valid    : per read port, rd_data refreshed this cycle
//   wr_conflict : registered pulse, two or more live writers hit one address
// ---------------------------------------------------------------------------
interface regfile_if #(
  parameter int SIZE        = 32,
  parameter int REG_NUM     = 64,
  parameter int READ_PORTS  = 4,
  parameter int WRITE_PORTS = 3
);
  import regfile_pkg::*;

  localparam int AW = addr_w(REG_NUM);

  logic                                ready;
  logic [WRITE_PORTS-1:0]              wr_en;
  logic [WRITE_PORTS-1:0][AW-1:0]      wr_addr;
  logic [WRITE_PORTS-1:0][SIZE-1:0]    wr_data;
  logic [READ_PORTS-1:0]               rd_en;
  logic [READ_PORTS-1:0][AW-1:0]       rd_addr;
  logic [READ_PORTS-1:0][SIZE-1:0]     rd_data;
  logic [READ_PORTS-1:0]               rd_valid;
  logic                                wr_conflict;

  modport master (
    input  ready, rd_data, rd_valid, wr_conflict,
    output wr_en, wr_addr, wr_data, rd_en, rd_addr
  );

  modport slave (
    output ready, rd_data, rd_valid, wr_conflict,
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr
  );

endinterface

// File: rtl/regfile_wr_arb.sv
// ---------------------------------------------------------------------------
// regfile_wr_arb
// Combinational write arbitration.
//   wr_en    in  per-port write enable
//   wr_addr  in  per-port write address
//   wr_mask  out per-port effective write enable after zero-register
//                filtering and same-address priority (highest index wins)
//   conflict out two or more live writers target the same address
// ---------------------------------------------------------------------------
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter  int REG_NUM     = 64,
  parameter  int WRITE_PORTS = 3,
  parameter  int ZERO_REG    = 1,
  localparam int AW          = addr_w(REG_NUM)
) (
  input  logic [WRITE_PORTS-1:0]         wr_en,
  input  logic [WRITE_PORTS-1:0][AW-1:0] wr_addr,
  output logic [WRITE_PORTS-1:0]         wr_mask,
  output logic                           conflict
);

  logic [WRITE_PORTS-1:0] live_s;
  logic                   hit_s;

  // Drop disabled ports and, with a hard-wired zero register, writes to it
  always_comb begin
    live_s = {WRITE_PORTS{1'b0}};
    for (int i = 0; i < WRITE_PORTS; i++) begin
      live_s[i] = wr_en[i] &
                  ~((ZERO_REG != 32'sd0) && (wr_addr[i] == {AW{1'b0}}));
    end
  end

  // A live port is masked off whenever a higher-index live port shares its address
  always_comb begin
    wr_mask  = live_s;
    conflict = 1'b0;
    hit_s    = 1'b0;
    for (int i = 0; i < WRITE_PORTS; i++) begin
      for (int j = i + 1; j < WRITE_PORTS; j++) begin
        hit_s      = live_s[i] & live_s[j] & (wr_addr[i] == wr_addr[j]);
        wr_mask[i] = wr_mask[i] & ~hit_s;
        conflict   = conflict | hit_s;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Multi-port register file: WRITE_PORTS writers, READ_PORTS readers, one
// cycle read latency, sequenced clear after reset.
//   clk  in  clock, all state on posedge
//   rst  in  synchronous active-high reset; restarts the clear sweep
//   bus  slave modport of regfile_if (ready, wr_*, rd_*, wr_conflict)
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read in the same cycle as a write to
//                      the same address returns the winning new data;
//                      otherwise it returns the pre-write contents.
// ---------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int SIZE        = 32,
  parameter  int REG_NUM     = 64,
  parameter  int READ_PORTS  = 4,
  parameter  int WRITE_PORTS = 3,
  parameter  int ZERO_REG    = 1,
  localparam int AW          = addr_w(REG_NUM)
) (
  input  logic     clk,
  input  logic     rst,
  regfile_if.slave bus
);

  logic [SIZE-1:0]                  regs_r [REG_NUM];
  rf_state_e                        state_r;
  rf_state_e                        state_nxt_s;
  logic [AW-1:0]                    clr_cnt_r;
  logic                             clr_act_s;
  logic                             run_act_s;
  logic                             ready_r;
  logic [WRITE_PORTS-1:0]           wr_mask_s;
  logic                             conflict_s;
  logic                             wr_conflict_r;
  logic [READ_PORTS-1:0][SIZE-1:0]  rd_value_s;
  logic [READ_PORTS-1:0][SIZE-1:0]  rd_data_r;
  logic [READ_PORTS-1:0]            rd_valid_r;

  regfile_wr_arb #(
    .REG_NUM     (REG_NUM),
    .WRITE_PORTS (WRITE_PORTS),
    .ZERO_REG    (ZERO_REG)
  ) u_wr_arb (
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .wr_mask  (wr_mask_s),
    .conflict (conflict_s)
  );

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RF_CLEAR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Leave CLEAR once the last register has been zeroed
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RF_CLEAR: state_nxt_s = (clr_cnt_r == AW'(REG_NUM - 1)) ? RF_RUN : RF_CLEAR;
      RF_RUN:   state_nxt_s = RF_RUN;
      default:  state_nxt_s = RF_CLEAR;
    endcase
  end

  // State decode into datapath qualifiers
  always_comb begin
    clr_act_s = 1'b0;
    run_act_s = 1'b0;
    case (state_r)
      RF_CLEAR: clr_act_s = 1'b1;
      RF_RUN:   run_act_s = 1'b1;
      default: begin
        clr_act_s = 1'b0;
        run_act_s = 1'b0;
      end
    endcase
  end

  // Clear sweep pointer; wraps to zero as the sweep completes
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt_r <= {AW{1'b0}};
    end else if (clr_act_s) begin
      clr_cnt_r <= clr_cnt_r + AW'(1);
    end else begin
      clr_cnt_r <= clr_cnt_r;
    end
  end

  // ready tracks the state the controller is entering, so it rises with RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= (state_nxt_s == RF_RUN);
    end
  end

  // Storage: one zero per cycle while clearing, arbitrated port writes in RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      // contents are swept to zero by the clear sequence that follows
    end else if (clr_act_s) begin
      regs_r[clr_cnt_r] <= {SIZE{1'b0}};
    end else if (run_act_s) begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (wr_mask_s[w]) begin
          regs_r[bus.wr_addr[w]] <= bus.wr_data[w];
        end
      end
    end
  end

  // Read operand select: array, optional same-cycle bypass, zero register
  always_comb begin
    rd_value_s = {(READ_PORTS * SIZE){1'b0}};
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_value_s[p] = regs_r[bus.rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      // at most one mask bit is set per address, so order does not matter
      for (int w = 0; w < WRITE_PORTS; w++) begin
        rd_value_s[p] = (wr_mask_s[w] && (bus.wr_addr[w] == bus.rd_addr[p]))
                        ? bus.wr_data[w] : rd_value_s[p];
      end
`else
      // reads see the pre-write contents; the write lands at this same edge
`endif
      rd_value_s[p] = ((ZERO_REG != 32'sd0) && (bus.rd_addr[p] == {AW{1'b0}}))
                      ? {SIZE{1'b0}} : rd_value_s[p];
    end
  end

  // Registered read ports; data holds when a port is idle or during CLEAR
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r  <= {(READ_PORTS * SIZE){1'b0}};
      rd_valid_r <= {READ_PORTS{1'b0}};
    end else begin
      for (int p = 0; p < READ_PORTS; p++) begin
        if (run_act_s && bus.rd_en[p]) begin
          rd_valid_r[p] <= 1'b1;
          rd_data_r[p]  <= rd_value_s[p];
        end else begin
          rd_valid_r[p] <= 1'b0;
          rd_data_r[p]  <= rd_data_r[p];
        end
      end
    end
  end

  // Conflict pulse, only meaningful while serving traffic
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_conflict_r <= 1'b0;
    end else begin
      wr_conflict_r <= run_act_s & conflict_s;
    end
  end

  assign bus.ready       = ready_r;
  assign bus.rd_data     = rd_data_r;
  assign bus.rd_valid    = rd_valid_r;
  assign bus.wr_conflict = wr_conflict_r;

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
// Scoreboard bench for regfile_mp. The stimulus side evaluates a plain array
// model of the register file for each upcoming clock edge and queues the
// expected status and read results; a monitor compares them after each edge.
// ---------------------------------------------------------------------------
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int SIZE    = 32;
  localparam int REG_NUM = 64;
  localparam int RP      = 4;
  localparam int WP      = 3;
  localparam int ZR      = 1;
  localparam int AW      = addr_w(REG_NUM);

  typedef struct packed {
    int unsigned                due;
    logic                       ready;
    logic                       conflict;
    logic [RP-1:0]              valid;
    logic [RP-1:0][SIZE-1:0]    hold;
  } status_t;

  typedef struct packed {
    int unsigned     due;
    int unsigned     port;
    logic [SIZE-1:0] data;
  } read_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned edge_cnt = 0;
  int          vec_cnt  = 0;
  int          err_cnt  = 0;

  status_t     st_q[$];
  read_t       rd_q[$];

  logic [SIZE-1:0]         m_regs [REG_NUM];
  int                      m_busy = REG_NUM;
  logic [RP-1:0][SIZE-1:0] m_hold = '0;

  regfile_if #(.SIZE(SIZE), .REG_NUM(REG_NUM), .READ_PORTS(RP), .WRITE_PORTS(WP)) rf_bus ();

  regfile_mp #(
    .SIZE(SIZE), .REG_NUM(REG_NUM), .READ_PORTS(RP), .WRITE_PORTS(WP), .ZERO_REG(ZR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s @edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
    end
  endfunction

  function automatic bit live_wr(input int i);
    return rf_bus.wr_en[i] && !((ZR != 0) && (rf_bus.wr_addr[i] == '0));
  endfunction

  // Model the coming posedge with the inputs currently driven, queue the
  // expectations, then move to the next falling edge.
  task automatic tick();
    status_t         st;
    read_t           rd;
    logic [SIZE-1:0] pre [REG_NUM];
    logic [AW-1:0]   a;
    st.due      = edge_cnt + 1;
    st.conflict = 1'b0;
    st.valid    = '0;
    st.ready    = 1'b0;
    if (rst) begin
      for (int r = 0; r < REG_NUM; r++) m_regs[r] = '0;
      m_busy = REG_NUM;
      m_hold = '0;
    end else if (m_busy > 0) begin
      m_busy--;
      st.ready = (m_busy == 0);
    end else begin
      st.ready = 1'b1;
      pre = m_regs;
      // ascending order: the highest-index writer is the one left standing
      for (int i = 0; i < WP; i++) begin
        if (live_wr(i)) begin
          for (int j = i + 1; j < WP; j++)
            if (live_wr(j) && rf_bus.wr_addr[j] == rf_bus.wr_addr[i]) st.conflict = 1'b1;
          m_regs[rf_bus.wr_addr[i]] = rf_bus.wr_data[i];
        end
      end
      for (int p = 0; p < RP; p++) begin
        if (rf_bus.rd_en[p]) begin
          a = rf_bus.rd_addr[p];
`ifdef REGFILE_BYPASS_EN
          rd.data = m_regs[a];
`else
          rd.data = pre[a];
`endif
          if (ZR != 0 && a == '0) rd.data = '0;
          rd.due  = st.due;
          rd.port = p;
          rd_q.push_back(rd);
          m_hold[p]   = rd.data;
          st.valid[p] = 1'b1;
        end
      end
    end
    st.hold = m_hold;
    st_q.push_back(st);
    @(negedge clk);
  endtask

  task automatic idle_in();
    rf_bus.wr_en   = '0;
    rf_bus.wr_addr = '0;
    rf_bus.wr_data = '0;
    rf_bus.rd_en   = '0;
    rf_bus.rd_addr = '0;
  endtask

  task automatic read_all(input logic [AW-1:0] a);
    idle_in();
    rf_bus.rd_en = '1;
    for (int p = 0; p < RP; p++) rf_bus.rd_addr[p] = a;
    tick();
  endtask

  task automatic write1(input int port, input logic [AW-1:0] a, input logic [SIZE-1:0] d);
    rf_bus.wr_en[port]   = 1'b1;
    rf_bus.wr_addr[port] = a;
    rf_bus.wr_data[port] = d;
  endtask

  // Monitor: compare queued expectations against what the DUT presents
  initial begin
    status_t st;
    read_t   rd;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0 && st_q[0].due == edge_cnt) begin
        st = st_q.pop_front();
        chk("ready", {63'd0, rf_bus.ready}, {63'd0, st.ready});
        chk("wr_conflict", {63'd0, rf_bus.wr_conflict}, {63'd0, st.conflict});
        chk("rd_valid", 64'(rf_bus.rd_valid), 64'(st.valid));
        for (int p = 0; p < RP; p++)
          if (!rf_bus.rd_valid[p]) chk("rd_hold", 64'(rf_bus.rd_data[p]), 64'(st.hold[p]));
      end
      for (int p = 0; p < RP; p++) begin
        if (rf_bus.rd_valid[p]) begin
          if (rd_q.size() == 0 || rd_q[0].port != p || rd_q[0].due != edge_cnt) begin
            chk("rd_unexpected", 64'(p), 64'hFFFF);
          end else begin
            rd = rd_q.pop_front();
            chk("rd_data", 64'(rf_bus.rd_data[p]), 64'(rd.data));
          end
        end
      end
      while (rd_q.size() > 0 && rd_q[0].due <= edge_cnt) begin
        rd = rd_q.pop_front();
        chk("rd_missing", 64'(0), 64'(rd.port + 1));
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_in();
    @(negedge clk);

    // reset, full clear sweep, then every register reads zero
    repeat (3) tick();
    rst = 1'b0;
    repeat (REG_NUM) tick();
    for (int k = 0; k < REG_NUM / RP; k++) begin
      idle_in();
      rf_bus.rd_en = '1;
      for (int p = 0; p < RP; p++) rf_bus.rd_addr[p] = AW'(k * RP + p);
      tick();
    end

    // single write then broadcast read
    idle_in(); write1(0, 6'd5, 32'hA5A5_0001); tick();
    read_all(6'd5);

    // three writers on one address: conflict pulse, highest port wins
    idle_in();
    write1(0, 6'd9, 32'h11); write1(1, 6'd9, 32'h22); write1(2, 6'd9, 32'h33);
    tick();
    idle_in(); tick();
    read_all(6'd9);

    // same-cycle write and read of one address
    idle_in(); write1(0, 6'd7, 32'h1234); tick();
    idle_in(); write1(1, 6'd7, 32'hBEEF);
    rf_bus.rd_en[0] = 1'b1; rf_bus.rd_addr[0] = 6'd7;
    tick();
    read_all(6'd7);

    // writes to the zero register: no conflict, still reads zero
    idle_in(); write1(0, 6'd0, 32'hFFFF_FFFF); write1(1, 6'd0, 32'hFFFF_FFFF); tick();
    read_all(6'd0);

    // randomised traffic with rare resets
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < WP; i++) begin
        rf_bus.wr_en[i]   = $urandom_range(0, 1);
        rf_bus.wr_addr[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        rf_bus.wr_data[i] = $urandom;
      end
      for (int p = 0; p < RP; p++) begin
        rf_bus.rd_en[p]   = $urandom_range(0, 1);
        rf_bus.rd_addr[p] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      end
      tick();
    end
    rst = 1'b0;
    idle_in();
    repeat (REG_NUM + 2) tick();

    // reset again in the middle of a clear sweep after RUN writes
    write1(0, 6'd10, 32'hCAFE_0010); write1(1, 6'd11, 32'hCAFE_0011); write1(2, 6'd12, 32'hCAFE_0012);
    tick();
    idle_in();
    rst = 1'b1; tick();
    rst = 1'b0; repeat (30) tick();
    rst = 1'b1; tick();
    rst = 1'b0; repeat (REG_NUM) tick();
    idle_in();
    rf_bus.rd_en = '1;
    rf_bus.rd_addr[0] = 6'd10; rf_bus.rd_addr[1] = 6'd11;
    rf_bus.rd_addr[2] = 6'd12; rf_bus.rd_addr[3] = 6'd5;
    tick();
    idle_in();
    repeat (2) tick();

    @(posedge clk);
    #2;
    chk("drain", 64'(st_q.size() + rd_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
